// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, line geometry and address helpers for the instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    localparam int LINE_BYTES = 8;
    localparam int OFFSET_W   = 3;
    localparam int MAX_ADDR_W = 64;

    // Callers zero-extend narrower addresses into this width and slice the result back.
    function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr);
        return {addr[MAX_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - valid/tag/data line storage with combinational read and one write port
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int TAG_W     = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_LINES)-1:0] i_rd_idx,
    output logic                         o_rd_valid,
    output logic [TAG_W-1:0]             o_rd_tag,
    output logic [LINE_BYTES*8-1:0]      o_rd_data,
    input  logic                         i_we,
    input  logic [$clog2(NUM_LINES)-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]             i_wr_tag,
    input  logic [LINE_BYTES*8-1:0]      i_wr_data,
    input  logic                         i_clear_all
);

    logic [NUM_LINES-1:0]      r_valid;
    logic [TAG_W-1:0]          r_tag  [NUM_LINES];
    logic [LINE_BYTES*8-1:0]   r_data [NUM_LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_clear_all) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_fill_controller.sv
// rtl/icache_fill_controller.sv - direct-mapped icache fetch/refill controller; ICACHE_STATS_EN adds hit/miss counters
module icache_fill_controller
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [31:0]       cpu_instr,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              cache_miss,
    input  logic [63:0]       block,
    input  logic              cache_write
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_cpu_ready;
    logic [31:0]         r_cpu_instr;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_address;
    logic                r_cache_miss;

    logic                w_next_ready;
    logic [31:0]         w_next_instr;
    logic [ADDR_W-1:0]   w_next_address;
    logic                w_next_miss;
    logic                w_latch_req;
    logic                w_we;
    logic                w_clear_all;
    logic                w_hit;

    logic [IDX_W-1:0]    w_req_idx;
    logic [TAG_W-1:0]    w_req_tag;
    logic                w_rd_valid;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [63:0]         w_rd_data;
    logic [MAX_ADDR_W-1:0] w_aligned_full;
    logic [ADDR_W-1:0]   w_aligned;

    assign w_req_idx      = r_req_addr[OFFSET_W +: IDX_W];
    assign w_req_tag      = r_req_addr[ADDR_W-1 -: TAG_W];
    assign w_aligned_full = line_align(MAX_ADDR_W'(r_req_addr));
    assign w_aligned      = w_aligned_full[ADDR_W-1:0];
    assign w_hit          = w_rd_valid && (w_rd_tag == w_req_tag);

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (w_req_idx),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_we        (w_we),
        .i_wr_idx    (w_req_idx),
        .i_wr_tag    (w_req_tag),
        .i_wr_data   (block),
        .i_clear_all (w_clear_all)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_ready   = 1'b0;
        w_next_instr   = r_cpu_instr;
        w_next_address = r_address;
        w_next_miss    = r_cache_miss;
        w_latch_req    = 1'b0;
        w_we           = 1'b0;
        w_clear_all    = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_clear_all = 1'b1;
                end else if (cpu_req) begin
                    w_latch_req  = 1'b1;
                    w_next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    w_next_ready = 1'b1;
                    w_next_instr = r_req_addr[2] ? w_rd_data[63:32] : w_rd_data[31:0];
                    w_next_state = IDLE;
                end else begin
                    w_next_miss    = 1'b1;
                    w_next_address = w_aligned;
                    w_next_state   = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // Strobes outside this state never reach the array.
                if (cache_write) begin
                    w_we         = 1'b1;
                    w_next_miss  = 1'b0;
                    w_next_state = LOOKUP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_req_addr   <= '0;
            r_cpu_ready  <= 1'b0;
            r_cpu_instr  <= '0;
            r_busy       <= 1'b0;
            r_address    <= '0;
            r_cache_miss <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cpu_ready  <= w_next_ready;
            r_cpu_instr  <= w_next_instr;
            r_busy       <= (w_next_state != IDLE);
            r_address    <= w_next_address;
            r_cache_miss <= w_next_miss;
            if (w_latch_req) begin
                r_req_addr <= cpu_addr;
            end
        end
    end

    assign cpu_ready  = r_cpu_ready;
    assign cpu_instr  = r_cpu_instr;
    assign busy       = r_busy;
    assign address    = r_address;
    assign cache_miss = r_cache_miss;

`ifdef ICACHE_STATS_EN
    logic        r_refill_lookup;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // The lookup that follows a refill always hits and is not a real hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refill_lookup <= 1'b0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
        end else begin
            if (r_state == MISS_WAIT && cache_write) begin
                r_refill_lookup <= 1'b1;
            end else if (r_state == LOOKUP) begin
                r_refill_lookup <= 1'b0;
            end
            if (r_state == LOOKUP && w_hit && !r_refill_lookup && r_hit_count != 32'hFFFF_FFFF) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (r_state == LOOKUP && !w_hit && r_miss_count != 32'hFFFF_FFFF) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_fill_controller.sv
// tb/tb_icache_fill_controller.sv - randomized self-checking bench against a line-level cache model
module tb_icache_fill_controller;

    localparam int NUM_LINES = 16;
    localparam int ADDR_W    = 32;
    localparam int MEM_LAT   = 9;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              flush;
    logic              cpu_ready;
    logic [31:0]       cpu_instr;
    logic              busy;
    logic [ADDR_W-1:0] address;
    logic              cache_miss;
    logic [63:0]       block;
    logic              cache_write;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    icache_fill_controller #(
        .NUM_LINES (NUM_LINES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .flush       (flush),
        .cpu_ready   (cpu_ready),
        .cpu_instr   (cpu_instr),
        .busy        (busy),
        .address     (address),
        .cache_miss  (cache_miss),
        .block       (block),
        .cache_write (cache_write)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_valid [NUM_LINES];
    logic [31:0] m_tag   [NUM_LINES];
    logic [63:0] m_data  [NUM_LINES];
    logic [63:0] mem     [logic [31:0]];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [31:0] al);
        if (!mem.exists(al)) mem[al] = {$urandom, $urandom};
        return mem[al];
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        flush   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where cpu_ready is seen, cpu_req still high.
    task automatic fetch(input logic [31:0] a);
        int          idx;
        logic [31:0] tg;
        logic [31:0] al;
        bit          exp_hit;
        bit          saw_miss;
        bit          hold_ok;
        bit          got_ready;
        int          cyc;
        int          miss_c;
        idx      = int'((a / 8) % NUM_LINES);
        tg       = a / (8 * NUM_LINES);
        al       = a & ~32'h7;
        exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
        saw_miss = 1'b0;
        hold_ok  = 1'b1;
        got_ready = 1'b0;
        cyc      = 0;
        miss_c   = 0;
        cpu_addr = a;
        cpu_req  = 1'b1;
        while (!got_ready && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            cache_write = 1'b0;
            if (cache_miss && !saw_miss) begin
                saw_miss = 1'b1;
                miss_c   = cyc;
                check("miss_addr", 64'(address), 64'(al));
            end
            if (saw_miss && cyc <= miss_c + MEM_LAT && (!cache_miss || address !== al)) hold_ok = 1'b0;
            if (saw_miss && cyc == miss_c + MEM_LAT) begin
                block       = mem_read(al);
                cache_write = 1'b1;
            end
            if (cpu_ready) got_ready = 1'b1;
        end
        check("ready_seen", 64'(got_ready), 64'd1);
        check("miss_flag", 64'(saw_miss), 64'(!exp_hit));
        check("latency", 64'(cyc - 1), exp_hit ? 64'd1 : 64'(MEM_LAT + 3));
        if (exp_hit) begin
            m_hits++;
        end else begin
            check("miss_hold", 64'(hold_ok), 64'd1);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_read(al);
            m_misses++;
        end
        check("instr", 64'(cpu_instr), a[2] ? 64'(m_data[idx][63:32]) : 64'(m_data[idx][31:0]));
        check("miss_low", 64'(cache_miss), 64'd0);
    endtask

    task automatic spurious_strobe();
        block       = {$urandom, $urandom};
        cache_write = 1'b1;
        @(negedge clk);
        cache_write = 1'b0;
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_miss", 64'(cache_miss), 64'd0);
    endtask

    task automatic flush_with_req(input logic [31:0] a);
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        flush   = 1'b0;
        cpu_req = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_ready", 64'(cpu_ready), 64'd0);
        model_invalidate();
    endtask

    initial begin
        int w;
        logic [31:0] ra;
        reset       = 1'b0;
        cpu_req     = 1'b0;
        cpu_addr    = '0;
        flush       = 1'b0;
        block       = '0;
        cache_write = 1'b0;
        model_invalidate();
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cpu_ready), 64'd0);
        check("rst_miss", 64'(cache_miss), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_instr", 64'(cpu_instr), 64'd0);
        check("rst_addr", 64'(address), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        mem[32'h10] = 64'h1111_2222_3333_4444;
        fetch(32'h0000_0010);
        check("cold_instr", 64'(cpu_instr), 64'h3333_4444);
        idle(1);
        fetch(32'h0000_0014);
        check("hit_instr", 64'(cpu_instr), 64'h1111_2222);
`ifdef ICACHE_STATS_EN
        check("stat_hits", 64'(hit_count), 64'd1);
        check("stat_misses", 64'(miss_count), 64'd1);
`endif
        idle(1);
        fetch(32'h0000_0090);
        idle(1);
        fetch(32'h0000_0010);
        idle(1);

        flush_with_req(32'h0000_0010);
        @(negedge clk);
        check("flush_idle", 64'(busy), 64'd0);
        fetch(32'h0000_0010);
        idle(1);

        cpu_addr = 32'h0000_0020;
        cpu_req  = 1'b1;
        w = 0;
        while (!cache_miss && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rm_miss_seen", 64'(cache_miss), 64'd1);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rm_async_miss", 64'(cache_miss), 64'd0);
        check("rm_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_invalidate();
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        block       = mem_read(32'h20);
        cache_write = 1'b1;
        @(negedge clk);
        cache_write = 1'b0;
        check("late_busy", 64'(busy), 64'd0);
        fetch(32'h0000_0020);
        idle(1);

        fetch(32'h0000_0028);
        idle(1);
        spurious_strobe();
        fetch(32'h0000_002C);
        idle(1);
        fetch(32'h0000_0030);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            w = $urandom_range(0, 9);
            if (w == 0) begin
                idle(1);
                flush_with_req(32'($urandom));
            end else if (w == 1) begin
                idle(1);
                spurious_strobe();
            end else begin
                ra = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
                fetch(ra);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(2);
`ifdef ICACHE_STATS_EN
        check("stat_hits_end", 64'(hit_count), 64'(m_hits));
        check("stat_misses_end", 64'(miss_count), 64'(m_misses));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
